arbitro_writeback: RTL and testbench

- Shares the single write port of the 32x32 register file among NREQ writeback requesters (e.g. ALU, load unit, I/O), one write per cycle.
- Also keeps a per-register pending scoreboard so decode can detect RAW hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's regWrite/RD/dadosEscrita inputs from registered outputs.

---
 rtl/reg_pkg.sv | 22 ++
 rtl/arbitro_writeback_rr_arbiter.sv | 64 ++++++
 rtl/arbitro_writeback.sv | 110 +++++++++++
 tb/tb_arbitro_writeback.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// reg_pkg : register-file geometry, index/word types and helpers
// Revision: 1.0
// ============================================================================
package reg_pkg;

   localparam int NREG   = 32;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = '0;

   function automatic logic [NREG-1:0] reg_onehot(input reg_idx_t idx);
      return NREG'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_writeback_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant with registered search pointer
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] cand;
   logic [PTR_W:0]   sum;
   logic             found;

   // Walk the requesters starting at the pointer; the first valid one wins.
   always_comb begin
      grant  = '0;
      winner = ptr_q;
      found  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N)) begin
            sum = sum - (PTR_W+1)'(N);
         end
         cand = sum[PTR_W-1:0];
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      if (found && !reset) begin
         grant[winner] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (winner == PTR_W'(N-1)) ? '0 : winner + PTR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/arbitro_writeback.sv
`default_nettype none
// ============================================================================
// arbitro_writeback : register-file write-port arbiter with RAW scoreboard
// Optional macro WB_BYPASS_EN adds the byp_valid/byp_rd/byp_data forwarding port.
// Revision: 1.0
// ============================================================================
module arbitro_writeback #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*REG_W-1:0]  req_rd,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   reserve_valid,
   input  logic [REG_W-1:0]       reserve_rd,
   output logic [31:0]            pending,
   output logic                   regWrite,
   output logic [REG_W-1:0]       RD,
   output logic [DATA_W-1:0]      dadosEscrita
`ifdef WB_BYPASS_EN
   ,
   output logic                   byp_valid,
   output logic [REG_W-1:0]       byp_rd,
   output logic [DATA_W-1:0]      byp_data
`endif
);

   import reg_pkg::*;

   logic [NREQ-1:0]   grant;
   logic              accept;
   logic [REG_W-1:0]  sel_rd;
   logic [DATA_W-1:0] sel_data;

   logic              reg_write_d, reg_write_q;
   logic [REG_W-1:0]  rd_d, rd_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic [NREG-1:0]   pending_d, pending_q;

   rr_arbiter #(
      .N (NREQ)
   ) u_rr_arbiter (
      .clock   (clock),
      .reset   (reset),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);

   // Grant is one-hot, so OR-ing the gated slices selects the winner.
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_rd   = sel_rd   | req_rd[i*REG_W +: REG_W];
            sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Clear on retire first, then set on reserve so the newer owner wins.
   always_comb begin
      reg_write_d = accept && (sel_rd != REG_ZERO);
      rd_d        = accept ? sel_rd   : rd_q;
      data_d      = accept ? sel_data : data_q;
      pending_d   = pending_q;
      if (accept) begin
         pending_d = pending_d & ~reg_onehot(reg_idx_t'(sel_rd));
      end
      if (reserve_valid && (reserve_rd != REG_ZERO)) begin
         pending_d = pending_d | reg_onehot(reg_idx_t'(reserve_rd));
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         data_q      <= '0;
         pending_q   <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         pending_q   <= pending_d;
      end
   end

   assign regWrite     = reg_write_q;
   assign RD           = rd_q;
   assign dadosEscrita = data_q;
   assign pending      = pending_q;

`ifdef WB_BYPASS_EN
   assign byp_valid = reg_write_q;
   assign byp_rd    = rd_q;
   assign byp_data  = data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arbitro_writeback.sv
`default_nettype none
// ============================================================================
// tb_arbitro_writeback : directed scenarios plus randomized traffic vs. model
// Revision: 1.0
// ============================================================================
module tb_arbitro_writeback;

   localparam int NREQ   = 3;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*REG_W-1:0]  req_rd;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   reserve_valid;
   logic [REG_W-1:0]       reserve_rd;
   logic [31:0]            pending;
   logic                   regWrite;
   logic [REG_W-1:0]       RD;
   logic [DATA_W-1:0]      dadosEscrita;
`ifdef WB_BYPASS_EN
   logic                   byp_valid;
   logic [REG_W-1:0]       byp_rd;
   logic [DATA_W-1:0]      byp_data;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state
   int                m_ptr  = 0;
   logic [31:0]       m_pend = '0;
   logic              m_rw   = 1'b0;
   logic [REG_W-1:0]  m_rd   = '0;
   logic [DATA_W-1:0] m_data = '0;

   arbitro_writeback #(
      .NREQ   (NREQ),
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_rd        (req_rd),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .reserve_valid (reserve_valid),
      .reserve_rd    (reserve_rd),
      .pending       (pending),
      .regWrite      (regWrite),
      .RD            (RD),
      .dadosEscrita  (dadosEscrita)
`ifdef WB_BYPASS_EN
      ,
      .byp_valid     (byp_valid),
      .byp_rd        (byp_rd),
      .byp_data      (byp_data)
`endif
   );

   always #5 clock = ~clock;

   function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (ptr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      logic [NREQ-1:0] r;
      int g;
      r = '0;
      g = model_grant(req_valid, m_ptr);
      if (!reset && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] d);
      req_valid[i]                 = v;
      req_rd[i*REG_W +: REG_W]     = rd;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   // Advance the model by the rules, then let the DUT take the same edge.
   task automatic tick();
      int g;
      logic [REG_W-1:0] r;
      g = model_grant(req_valid, m_ptr);
      if (reset) begin
         m_ptr = 0; m_pend = '0; m_rw = 1'b0; m_rd = '0; m_data = '0;
      end else begin
         if (g >= 0) begin
            r      = req_rd[g*REG_W +: REG_W];
            m_rw   = (r != 0);
            m_rd   = r;
            m_data = req_data[g*DATA_W +: DATA_W];
            m_ptr  = (g + 1) % NREQ;
            m_pend[r] = 1'b0;
         end else begin
            m_rw = 1'b0;
         end
         if (reserve_valid && reserve_rd != 0) m_pend[reserve_rd] = 1'b1;
         m_pend[0] = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_req(0, 1'b1, 5'd1, 32'h1);
      set_req(1, 1'b1, 5'd2, 32'h2);
      set_req(2, 1'b1, 5'd3, 32'h3);
      tick();
      tick();
      checks++;
      if (req_ready !== 3'b000) begin
         errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 3'b000);
      end
      checks++;
      if (regWrite !== 1'b0) begin
         errors++; $display("FAIL reset_regwrite: got %b expected 0", regWrite);
      end
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL reset_pending: got %h expected 0", pending);
      end
      checks++;
      if (RD !== 5'd0 || dadosEscrita !== 32'h0) begin
         errors++; $display("FAIL reset_rd_data: got %0d/%h expected 0/0", RD, dadosEscrita);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL reset_first_grant: got %b expected %b", req_ready, 3'b001);
      end
      req_valid = '0;
      #1;
   endtask

   task automatic test_round_robin();
      int exp_g[4]  = '{0, 1, 2, 0};
      int exp_rd[4] = '{3, 4, 5, 3};
      logic [NREQ-1:0] er;
      set_req(0, 1'b1, 5'd3, 32'hA);
      set_req(1, 1'b1, 5'd4, 32'hB);
      set_req(2, 1'b1, 5'd5, 32'hC);
      for (int k = 0; k < 4; k++) begin
         #1;
         er = '0;
         er[exp_g[k]] = 1'b1;
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, er);
         end
         tick();
         checks++;
         if (regWrite !== 1'b1 || RD !== 5'(exp_rd[k]) || dadosEscrita !== 32'hA + 32'(exp_g[k])) begin
            errors++;
            $display("FAIL rr_write[%0d]: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h",
                     k, regWrite, RD, dadosEscrita, exp_rd[k], 32'hA + 32'(exp_g[k]));
         end
      end
      req_valid = '0;
   endtask

   task automatic test_zero_reg();
      set_req(1, 1'b1, 5'd0, 32'hDEAD);
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++; $display("FAIL zero_ready: got %b expected %b", req_ready, 3'b010);
      end
      tick();
      req_valid[1] = 1'b0;
      set_req(2, 1'b1, 5'd6, 32'h66);
      #1;
      checks++;
      if (regWrite !== 1'b0) begin
         errors++; $display("FAIL zero_regwrite: got %b expected 0", regWrite);
      end
      checks++;
      if (req_ready !== 3'b100) begin
         errors++; $display("FAIL zero_next_grant: got %b expected %b", req_ready, 3'b100);
      end
      tick();
      req_valid = '0;
      checks++;
      if (regWrite !== 1'b1 || RD !== 5'd6) begin
         errors++; $display("FAIL zero_after_write: got we=%b rd=%0d expected we=1 rd=6", regWrite, RD);
      end
   endtask

   task automatic test_scoreboard();
      reserve_valid = 1'b1; reserve_rd = 5'd7;
      tick();
      reserve_valid = 1'b0;
      checks++;
      if (pending !== 32'h80) begin
         errors++; $display("FAIL sb_reserve: got %h expected %h", pending, 32'h80);
      end
      tick();
      tick();
      set_req(0, 1'b1, 5'd7, 32'h77);
      #1;
      checks++;
      if (req_ready !== 3'b001 || pending !== 32'h80) begin
         errors++; $display("FAIL sb_accept: got ready=%b pend=%h expected ready=001 pend=80", req_ready, pending);
      end
      tick();
      req_valid = '0;
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL sb_clear: got %h expected 0", pending);
      end
      checks++;
      if (regWrite !== 1'b1 || RD !== 5'd7 || dadosEscrita !== 32'h77) begin
         errors++; $display("FAIL sb_write: got we=%b rd=%0d data=%h expected 1/7/77", regWrite, RD, dadosEscrita);
      end
      reserve_valid = 1'b1; reserve_rd = 5'd0;
      tick();
      reserve_valid = 1'b0;
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL sb_reserve_zero: got %h expected 0", pending);
      end
   endtask

   task automatic test_conflict();
      reserve_valid = 1'b1; reserve_rd = 5'd9;
      tick();
      set_req(1, 1'b1, 5'd9, 32'h99);
      #1;
      checks++;
      if (req_ready !== 3'b010 || pending !== 32'h200) begin
         errors++; $display("FAIL conf_setup: got ready=%b pend=%h expected 010/200", req_ready, pending);
      end
      tick();
      req_valid = '0; reserve_valid = 1'b0;
      checks++;
      if (pending !== 32'h200) begin
         errors++; $display("FAIL conf_set_wins: got %h expected %h", pending, 32'h200);
      end
      checks++;
      if (regWrite !== 1'b1 || RD !== 5'd9) begin
         errors++; $display("FAIL conf_write: got we=%b rd=%0d expected 1/9", regWrite, RD);
      end
      set_req(2, 1'b1, 5'd9, 32'h9A);
      tick();
      req_valid = '0;
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL conf_clear: got %h expected 0", pending);
      end
   endtask

   task automatic test_mid_reset();
      reserve_valid = 1'b1; reserve_rd = 5'd20;
      set_req(0, 1'b1, 5'd1, 32'h11);
      tick();
      reserve_valid = 1'b0;
      set_req(0, 1'b1, 5'd1, 32'h11);
      set_req(1, 1'b1, 5'd2, 32'h22);
      set_req(2, 1'b1, 5'd3, 32'h33);
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
         errors++; $display("FAIL mid_reset_ready: got %b expected 000", req_ready);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (regWrite !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL mid_reset_state: got we=%b pend=%h expected 0/0", regWrite, pending);
      end
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL mid_reset_ptr: got %b expected 001", req_ready);
      end
      req_valid = '0;
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      set_req(1, 1'b1, 5'd12, 32'h55);
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (byp_valid !== 1'b1 || byp_rd !== 5'd12 || byp_data !== 32'h55) begin
         errors++; $display("FAIL byp_forward: got %b/%0d/%h expected 1/12/55", byp_valid, byp_rd, byp_data);
      end
      tick();
      checks++;
      if (byp_valid !== 1'b0) begin
         errors++; $display("FAIL byp_idle: got %b expected 0", byp_valid);
      end
   endtask
`endif

   task automatic test_random();
      logic [NREQ-1:0] er;
      int g;
      for (int n = 0; n < 400; n++) begin
         reset         = ($urandom_range(0, 39) == 0);
         reserve_valid = 1'($urandom_range(0, 1));
         reserve_rd    = 5'($urandom_range(0, 7));
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
         end
         #1;
         er = exp_ready();
         checks++;
         if (req_ready !== er) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, req_ready, er);
         end
         checks++;
         if (regWrite !== m_rw || (m_rw && (RD !== m_rd || dadosEscrita !== m_data))) begin
            errors++;
            $display("FAIL rand_write[%0d]: got %b/%0d/%h expected %b/%0d/%h",
                     n, regWrite, RD, dadosEscrita, m_rw, m_rd, m_data);
         end
         checks++;
         if (pending !== m_pend) begin
            errors++; $display("FAIL rand_pending[%0d]: got %h expected %h", n, pending, m_pend);
         end
`ifdef WB_BYPASS_EN
         checks++;
         if (byp_valid !== m_rw || (m_rw && (byp_rd !== m_rd || byp_data !== m_data))) begin
            errors++; $display("FAIL rand_bypass[%0d]: got %b/%0d/%h expected %b/%0d/%h",
                               n, byp_valid, byp_rd, byp_data, m_rw, m_rd, m_data);
         end
`endif
         g = reset ? -1 : model_grant(req_valid, m_ptr);
         tick();
         if (g >= 0) req_valid[g] = 1'b0;
      end
      reset = 1'b0;
      reserve_valid = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      reset         = 1'b1;
      req_valid     = '0;
      req_rd        = '0;
      req_data      = '0;
      reserve_valid = 1'b0;
      reserve_rd    = '0;
      test_reset();
      test_round_robin();
      test_zero_reg();
      test_scoreboard();
      test_conflict();
      test_mid_reset();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
